block_memory_model: RTL and testbench

Parametrised, reset-initialised block memory that backs the L2 cache in simulation and FPGA bring-up.
- Serves one whole-block read or write per request, with separately configurable read and write latencies.
- Supports per-word write masking, out-of-range detection, and clean abort of a withdrawn request.
- Sits under the L2 controller using the single-ported `mem_req`/`mem_miss` stall protocol.

---
 rtl/block_memory_model.sv | 149 ++++++++++++++
 tb/tb_block_memory_model.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/block_memory_model.sv
// Reset-initialised whole-block memory behind the L2 controller.
// One block read or write per request, stalled via mem_miss for a fixed per-op latency.
module block_memory_model #(
  parameter int BLOCKS        = 4,
  parameter int WORDS         = 4096,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4,
  parameter int INIT_MODE     = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_req,
  input  logic [31:0]              mem_addr,
  input  logic                     mem_we,
  input  logic [BLOCKS-1:0]        mem_write_mask,
  input  logic [BLOCKS-1:0][31:0]  mem_write_block,
  output logic [BLOCKS-1:0][31:0]  mem_read_block,
  output logic                     mem_miss,
  output logic                     mem_err
);

  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [15:0] RD_CNT = 16'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [15:0] WR_CNT = 16'((WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0);
  localparam bit RD_ONE = (READ_LATENCY == 1);
  localparam bit WR_ONE = (WRITE_LATENCY == 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_q, state_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [AW-1:0]            base_q;
  logic                     oor_q, we_q;
  logic [BLOCKS-1:0]        mask_q;
  logic [BLOCKS-1:0][31:0]  data_q;

  logic [31:0]              mem_q [WORDS];
  logic [BLOCKS-1:0][31:0]  rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic [31:0]              req_base;
  logic                     req_oor;
  logic                     in_idle, commit, miss_d;
  logic [AW-1:0]            op_base;
  logic                     op_oor, op_we;
  logic [BLOCKS-1:0]        op_mask;
  logic [BLOCKS-1:0][31:0]  op_data;
  logic [BLOCKS-1:0][31:0]  rd_gather;

  assign req_base = (mem_addr >> 2) & ~32'(BLOCKS - 1);
  assign req_oor  = (req_base >= 32'(WORDS));

  // A latency-1 request completes on the capture edge, so the operation
  // comes straight from the inputs in IDLE and from the captured copy otherwise.
  assign in_idle = (state_q == IDLE);
  assign op_base = in_idle ? req_base[AW-1:0] : base_q;
  assign op_oor  = in_idle ? req_oor          : oor_q;
  assign op_we   = in_idle ? mem_we           : we_q;
  assign op_mask = in_idle ? mem_write_mask   : mask_q;
  assign op_data = in_idle ? mem_write_block  : data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    miss_d  = 1'b0;
    case (state_q)
      IDLE: begin
        miss_d = mem_req;
        if (mem_req) begin
          if (mem_we ? WR_ONE : RD_ONE) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = mem_we ? WR_CNT : RD_CNT;
          end
        end
      end
      BUSY: begin
        miss_d = 1'b1;
        if (!mem_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DONE: begin
        miss_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit = (state_d == DONE);

  for (genvar gi = 0; gi < BLOCKS; gi++) begin : g_rd
    assign rd_gather[gi] = mem_q[op_base + AW'(gi)];
  end

  assign rdata_d = (commit && !op_we && !op_oor) ? rd_gather : '0;
  assign err_d   = commit && op_oor;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      oor_q   <= 1'b0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (in_idle && mem_req) begin
        base_q <= req_base[AW-1:0];
        oor_q  <= req_oor;
        we_q   <= mem_we;
        mask_q <= mem_write_mask;
        data_q <= mem_write_block;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < WORDS; w++) begin
        mem_q[w] <= (INIT_MODE == 1) ? (32'(w) << 2) : 32'd0;
      end
    end else if (commit && op_we && !op_oor) begin
      for (int i = 0; i < BLOCKS; i++) begin
        if (op_mask[i]) mem_q[op_base + AW'(i)] <= op_data[i];
      end
    end
  end

  // The stall must read low while reset is held, even with mem_req high.
  assign mem_miss       = reset & miss_d;
  assign mem_read_block = rdata_q;
  assign mem_err        = err_q;

endmodule

// File: tb/tb_block_memory_model.sv
// Directed bench for block_memory_model: word-array model with per-cycle output compare,
// plus literal expectations for the documented scenarios.
module tb_block_memory_model;

  typedef logic [3:0][31:0] blk_t;
  localparam int RL = 4;
  localparam int WL = 2;
  localparam int NW = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_miss, mem_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_write_mask;
  blk_t        mem_write_block, mem_read_block;

  logic        b_req, b_we, b_miss, b_err;
  logic [31:0] b_addr;
  logic [3:0]  b_mask;
  blk_t        b_wdata, b_rdata;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] model_mem [NW];
  logic        exp_miss, exp_err;
  blk_t        exp_block;
  bit          chk_en = 1'b0;

  block_memory_model #(
    .BLOCKS(4), .WORDS(NW), .READ_LATENCY(RL), .WRITE_LATENCY(WL), .INIT_MODE(1)
  ) dut (
    .clock(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_write_mask(mem_write_mask), .mem_write_block(mem_write_block),
    .mem_read_block(mem_read_block), .mem_miss(mem_miss), .mem_err(mem_err)
  );

  block_memory_model #(
    .BLOCKS(4), .WORDS(NW), .READ_LATENCY(1), .WRITE_LATENCY(1), .INIT_MODE(1)
  ) dut1 (
    .clock(clk), .reset(reset), .mem_req(b_req), .mem_addr(b_addr),
    .mem_we(b_we), .mem_write_mask(b_mask), .mem_write_block(b_wdata),
    .mem_read_block(b_rdata), .mem_miss(b_miss), .mem_err(b_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  function automatic void model_init();
    for (int w = 0; w < NW; w++) model_mem[w] = 32'(w) << 2;
  endfunction

  function automatic blk_t model_read(input int base);
    blk_t r;
    for (int i = 0; i < 4; i++) r[i] = model_mem[base + i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("miss",  128'(mem_miss), 128'(exp_miss));
      check("err",   128'(mem_err),  128'(exp_err));
      check("block", mem_read_block, exp_block);
    end
  end

  // One request from the IDLE cycle; drop_at = cycle index where mem_req falls (-1: never).
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [3:0] mask,
                        input blk_t data, input int drop_at,
                        output blk_t got_block, output logic got_err);
    int  lat, base;
    bit  oor, done;
    lat  = we ? WL : RL;
    base = int'((addr >> 2) & 32'hFFFF_FFFC);
    oor  = (base >= NW);
    done = (drop_at < 0) || (drop_at >= lat);
    got_block = '0;
    got_err   = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      if (c == 0) begin
        mem_req = 1'b1; mem_addr = addr; mem_we = we;
        mem_write_mask = mask; mem_write_block = data;
      end else begin
        mem_addr = $urandom; mem_we = ~we; mem_write_mask = 4'($urandom);
        mem_write_block = {$urandom, $urandom, $urandom, $urandom};
      end
      if (c == drop_at) mem_req = 1'b0;
      exp_miss  = (c < lat);
      exp_err   = (c == lat) && oor;
      exp_block = (c == lat && !we && !oor) ? model_read(base) : '0;
      @(negedge clk);
      if (c == lat) begin
        got_block = mem_read_block;
        got_err   = mem_err;
      end
      @(posedge clk); #1;
      if (c == drop_at) break;
    end
    if (done && we && !oor)
      for (int i = 0; i < 4; i++) if (mask[i]) model_mem[base + i] = data[i];
    mem_req = 1'b0; exp_miss = 1'b0; exp_err = 1'b0; exp_block = '0;
    $display("txn %s addr=%h mask=%b drop=%0d err=%0d data=%h",
             we ? "wr" : "rd", addr, mask, drop_at, got_err, got_block);
  endtask

  initial begin
    blk_t g, wd, b_exp [2];
    logic ge;

    reset = 1'b0; mem_req = 1'b1; mem_addr = 32'h40; mem_we = 1'b0;
    mem_write_mask = '0; mem_write_block = '0;
    b_req = 1'b1; b_addr = 32'h40; b_we = 1'b0; b_mask = '0; b_wdata = '0;
    exp_miss = 1'b0; exp_err = 1'b0; exp_block = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_miss",   128'(mem_miss), 128'(0));
    check("rst_err",    128'(mem_err),  128'(0));
    check("rst_block",  mem_read_block, 128'(0));
    check("rst_miss_b", 128'(b_miss),   128'(0));
    reset = 1'b1; mem_req = 1'b0; b_req = 1'b0;
    model_init();
    chk_en = 1'b1;
    @(posedge clk); #1;

    do_req(1'b0, 32'h40, 4'h0, '0, -1, g, ge);
    check("rd40", g, {32'h4C, 32'h48, 32'h44, 32'h40});
    check("rd40_err", 128'(ge), 128'(0));

    wd = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    do_req(1'b1, 32'h80, 4'b0101, wd, -1, g, ge);
    do_req(1'b0, 32'h80, 4'h0, '0, -1, g, ge);
    check("masked_wr80", g, {32'h8C, 32'hCCCC_CCCC, 32'h84, 32'hAAAA_AAAA});

    do_req(1'b1, 32'h100, 4'hF, wd, 1, g, ge);
    do_req(1'b0, 32'h100, 4'h0, '0, -1, g, ge);
    check("abort_rd100", g, {32'h10C, 32'h108, 32'h104, 32'h100});

    do_req(1'b0, 32'h10000, 4'h0, '0, -1, g, ge);
    check("oor_rd_block", g, 128'(0));
    check("oor_rd_err", 128'(ge), 128'(1));
    do_req(1'b1, 32'h10000, 4'hF, wd, -1, g, ge);
    check("oor_wr_err", 128'(ge), 128'(1));
    do_req(1'b0, 32'h0, 4'h0, '0, -1, g, ge);
    check("oor_wr_nochange", g, {32'hC, 32'h8, 32'h4, 32'h0});

    do_req(1'b0, 32'h3FF0, 4'h0, '0, -1, g, ge);
    check("last_block", g, {32'h3FFC, 32'h3FF8, 32'h3FF4, 32'h3FF0});
    check("last_block_err", 128'(ge), 128'(0));
    do_req(1'b0, 32'h4000, 4'h0, '0, -1, g, ge);
    check("first_oor_err", 128'(ge), 128'(1));
    do_req(1'b0, 32'h4E, 4'h0, '0, -1, g, ge);
    check("unaligned_rd", g, {32'h4C, 32'h48, 32'h44, 32'h40});

    wd = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hF00D_CAFE};
    do_req(1'b1, 32'h200, 4'hF, wd, WL, g, ge);
    do_req(1'b0, 32'h200, 4'h0, '0, -1, g, ge);
    check("wr_then_rd200", g, wd);

    chk_en = 1'b0;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_write_mask = 4'hF;
    mem_write_block = wd;
    @(negedge clk);
    check("midwr_miss_c0", 128'(mem_miss), 128'(1));
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("midwr_rst_miss",  128'(mem_miss), 128'(0));
    check("midwr_rst_err",   128'(mem_err),  128'(0));
    check("midwr_rst_block", mem_read_block, 128'(0));
    @(posedge clk); #1;
    mem_req = 1'b0; reset = 1'b1;
    model_init();
    chk_en = 1'b1;
    do_req(1'b0, 32'h40, 4'h0, '0, -1, g, ge);
    check("midwr_rd40", g, {32'h4C, 32'h48, 32'h44, 32'h40});

    b_exp[0] = {32'h4C, 32'h48, 32'h44, 32'h40};
    b_exp[1] = {32'h8C, 32'h88, 32'h84, 32'h80};
    b_req = 1'b1; b_addr = 32'h40; b_we = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) b_addr = 32'h80;
      @(negedge clk);
      check("b2b_miss", 128'(b_miss), 128'(((c % 2) == 0) ? 1 : 0));
      check("b2b_block", b_rdata, ((c % 2) == 1) ? b_exp[c / 2] : 128'(0));
      @(posedge clk); #1;
    end
    b_req = 1'b0;
    $display("txn b2b reads 0x40,0x80 at latency 1");

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
